// File: rtl/luz_fade_ctrl_pkg.sv
// luz_pkg: ASCII byte codes, duty word type, ramp states and level-letter decode
// Ports: none (package). Imported by every luz_fade_ctrl file.
package luz_pkg;
  localparam logic [7:0] CH_A = 8'd97;
  localparam logic [7:0] CH_Y = 8'd121;
  localparam logic [7:0] CH_0 = 8'd48;
  localparam logic [7:0] CH_ALL = 8'd42;
  localparam int DUTY_W_DEF = 16;
  typedef logic [DUTY_W_DEF-1:0] duty_t;
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DN} ramp_st_t;
  // 32-bit product leaves ample headroom over DUTY_W+8, so the clamp sees the true value
  function automatic logic [31:0] level_to_duty(input logic [7:0] b, input int unsigned step,
                                                input int unsigned duty_max);
    logic [31:0] p;
    p = (b == CH_Y) ? duty_max : 32'(b - CH_A) * step;
    return (p > duty_max) ? duty_max : p;
  endfunction
endpackage

// File: rtl/luz_fade_ctrl_if.sv
// luz_fade_ctrl_if: byte input, fade mode and per-channel duty/busy/err outputs
// master drives init/dato/fade_en (UART side); slave drives dutty/busy/err (controller)
interface luz_fade_ctrl_if #(
  parameter int N_CH   = 4,
  parameter int DUTY_W = 16
);
  logic                   init;
  logic [7:0]             dato;
  logic                   fade_en;
  logic [N_CH*DUTY_W-1:0] dutty;
  logic [N_CH-1:0]        busy;
  logic                   err;
  modport master (output init, dato, fade_en, input dutty, busy, err);
  modport slave (input init, dato, fade_en, output dutty, busy, err);
endinterface

// File: rtl/luz_fade_ctrl_ch.sv
// luz_fade_ch: one channel's target register, ramp FSM, duty and busy flag
// clk/rst; ld loads tgt_in into the target; fade_en selects ramp vs snap;
// tick is the shared fade strobe; dutty/busy are registered outputs
module luz_fade_ch
  import luz_pkg::*;
#(
  parameter int DUTY_W   = 16,
  parameter int FADE_INC = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              fade_en,
  input  logic              tick,
  input  logic [DUTY_W-1:0] tgt_in,
  output logic [DUTY_W-1:0] dutty,
  output logic              busy
);
  logic [DUTY_W-1:0] tgt_q, tgt_d, dutty_q, dutty_d, gap, step;
  logic              busy_q, busy_d;
  ramp_st_t          st_q, st_d;
  // st_q always holds the sign of tgt_q - dutty_q, so it picks the ramp direction
  always_comb begin
    gap = (st_q == ST_DN) ? dutty_q - tgt_q : tgt_q - dutty_q;
    step = (gap > DUTY_W'(FADE_INC)) ? DUTY_W'(FADE_INC) : gap;
    tgt_d = ld ? tgt_in : tgt_q;
    dutty_d = !fade_en ? tgt_q :
              !tick ? dutty_q :
              (st_q == ST_UP) ? dutty_q + step :
              (st_q == ST_DN) ? dutty_q - step : dutty_q;
    st_d = (tgt_d > dutty_d) ? ST_UP : (tgt_d < dutty_d) ? ST_DN : ST_IDLE;
    busy_d = st_d != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= '0;
      dutty_q <= '0;
      st_q <= ST_IDLE;
      busy_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      dutty_q <= dutty_d;
      st_q <= st_d;
      busy_q <= busy_d;
    end
  end
  assign dutty = dutty_q;
  assign busy = busy_q;
endmodule

// File: rtl/luz_fade_ctrl.sv
// luz_fade_ctrl: UART byte decoder driving N_CH fading PWM duty channels
// clk/rst plain; bus (slave): init/dato byte strobe, fade_en, dutty per channel,
// busy per channel, err pulse on an unrecognised byte
module luz_fade_ctrl
  import luz_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DUTY_W   = 16,
  parameter int STEP     = 2000,
  parameter int DUTY_MAX = 50000,
  parameter int FADE_DIV = 1000,
  parameter int FADE_INC = 100
) (
  input logic            clk,
  input logic            rst,
  luz_fade_ctrl_if.slave bus
);
  localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  logic [N_CH-1:0]        sel_q, sel_d, busy;
  logic                   err_q, err_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [7:0]             dig, lvl;
  logic                   is_dig, is_all, is_let, tick;
  logic [DUTY_W-1:0]      lvl_duty;
  logic [N_CH*DUTY_W-1:0] dutty;
  // bytes below '0' or 'a' wrap to large offsets, so one unsigned compare bounds each range
  always_comb begin
    dig = bus.dato - CH_0;
    lvl = bus.dato - CH_A;
    is_dig = dig < 8'(N_CH);
    is_all = bus.dato == CH_ALL;
    is_let = lvl <= (CH_Y - CH_A);
    lvl_duty = DUTY_W'(level_to_duty(bus.dato, STEP, DUTY_MAX));
    sel_d = !bus.init ? sel_q : is_dig ? N_CH'(1) << dig : is_all ? '1 : sel_q;
    err_d = bus.init & ~(is_dig | is_all | is_let);
    tick = (FADE_DIV == 1) || (pre_q == PW'(FADE_DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= N_CH'(1);
      err_q <= 1'b0;
      pre_q <= '0;
    end else begin
      sel_q <= sel_d;
      err_q <= err_d;
      pre_q <= pre_d;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    luz_fade_ch #(.DUTY_W(DUTY_W), .FADE_INC(FADE_INC)) u_ch (
      .clk(clk),
      .rst(rst),
      .ld(bus.init & is_let & sel_q[k]),
      .fade_en(bus.fade_en),
      .tick(tick),
      .tgt_in(lvl_duty),
      .dutty(dutty[k*DUTY_W +: DUTY_W]),
      .busy(busy[k])
    );
  end
  assign bus.dutty = dutty;
  assign bus.busy = busy;
  assign bus.err = err_q;
endmodule

// File: tb/tb_luz_fade_ctrl.sv
// tb_luz_fade_ctrl: directed scoreboard bench for luz_fade_ctrl (FADE_DIV=4)
module tb_luz_fade_ctrl;
  import luz_pkg::*;
  localparam int N_CH = 4;
  localparam int DUTY_W = 16;
  typedef struct {
    string tag;
    int    ch;
    int    val;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_tot = 0;
  int   n_pass = 0;
  int   err_cnt = 0;
  always #5 clk = ~clk;
  luz_fade_ctrl_if #(.N_CH(N_CH), .DUTY_W(DUTY_W)) bus ();
  luz_fade_ctrl #(.N_CH(N_CH), .DUTY_W(DUTY_W), .STEP(2000), .DUTY_MAX(50000),
                  .FADE_DIV(4), .FADE_INC(100)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(negedge clk) if (bus.err === 1'b1) err_cnt++;
  function automatic int dv(int ch);
    duty_t d;
    d = bus.dutty[ch*DUTY_W +: DUTY_W];
    return int'(d);
  endfunction
  task automatic chk(string tag, int obs, int exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] b);
    bus.init = 1'b1;
    bus.dato = b;
    step();
    bus.init = 1'b0;
    bus.dato = 8'd0;
  endtask
  task automatic push(string tag, int ch, int val);
    sb.push_back('{tag, ch, val});
  endtask
  task automatic push_all(string tag, int v0, int v1, int v2, int v3);
    push({tag, "_ch0"}, 0, v0);
    push({tag, "_ch1"}, 1, v1);
    push({tag, "_ch2"}, 2, v2);
    push({tag, "_ch3"}, 3, v3);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, (e.ch < 0) ? int'(bus.busy) : dv(e.ch), e.val);
    end
  endtask
  // pops one expected value per observed change of channel ch; ticks are 4 cycles apart
  task automatic follow(string tag, int ch, int lim);
    int   prev, gap, seen;
    exp_t e;
    prev = dv(ch);
    gap = 0;
    seen = 0;
    for (int c = 0; c < lim && sb.size() > 0; c++) begin
      step();
      gap++;
      if (dv(ch) != prev) begin
        e = sb.pop_front();
        chk(e.tag, dv(ch), e.val);
        if (seen > 0) chk({tag, "_period"}, gap, 4);
        seen++;
        gap = 0;
        prev = dv(ch);
      end
    end
    chk({tag, "_left"}, sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    int e0;
    bus.init = 1'b0;
    bus.dato = 8'd0;
    bus.fade_en = 1'b0;
    repeat (3) step();
    push_all("t1_rst", 0, 0, 0, 0);
    push("t1_rst_busy", -1, 0);
    drain();
    chk("t1_rst_err", int'(bus.err), 0);
    rst = 1'b0;
    step();
    send("c");
    chk("t1_E_dutty", dv(0), 0);
    chk("t1_E_busy", int'(bus.busy), 1);
    step();
    push_all("t1_c", 4000, 0, 0, 0);
    push("t1_c_busy", -1, 0);
    drain();
    send("2");
    send("y");
    step();
    push_all("t2_y", 4000, 0, 50000, 0);
    drain();
    send("*");
    send("a");
    step();
    push_all("t2_all_a", 0, 0, 0, 0);
    drain();
    bus.fade_en = 1'b1;
    send("1");
    send("b");
    chk("t3_busy_start", int'(bus.busy), 2);
    for (int v = 100; v <= 2000; v += 100) push("t3_ramp", 1, v);
    follow("t3", 1, 200);
    chk("t3_busy_end", int'(bus.busy), 0);
    chk("t3_ch0_hold", dv(0), 0);
    bus.fade_en = 1'b0;
    send("a");
    step();
    chk("t4_snap0", dv(1), 0);
    bus.fade_en = 1'b1;
    send("b");
    for (int c = 0; c < 200 && dv(1) != 700; c++) step();
    chk("t4_reach700", dv(1), 700);
    send("a");
    for (int v = 600; v >= 0; v -= 100) push("t4_down", 1, v);
    follow("t4", 1, 100);
    chk("t4_busy_end", int'(bus.busy), 0);
    bus.fade_en = 1'b0;
    step();
    chk("t5_err_quiet", err_cnt, 0);
    e0 = err_cnt;
    send("9");
    step();
    step();
    send("z");
    step();
    step();
    chk("t5_err_pulses", err_cnt - e0, 2);
    push_all("t5_hold", 0, 0, 0, 0);
    drain();
    send("c");
    step();
    push_all("t5_sel_kept", 0, 4000, 0, 0);
    drain();
    bus.fade_en = 1'b1;
    send("y");
    repeat (10) step();
    chk("t6_ramping", int'(bus.busy), 2);
    rst = 1'b1;
    step();
    push_all("t6_rst", 0, 0, 0, 0);
    push("t6_rst_busy", -1, 0);
    drain();
    rst = 1'b0;
    bus.fade_en = 1'b0;
    send("e");
    step();
    push_all("t6_e", 8000, 0, 0, 0);
    drain();
    send("x");
    step();
    push("t6_x", 0, 46000);
    drain();
    send("*");
    send("y");
    step();
    push_all("t6_bcast_y", 50000, 50000, 50000, 50000);
    push("t6_bcast_busy", -1, 0);
    drain();
    chk("t6_err_total", err_cnt, 2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
